mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, byte-address width of the CPU and memory address buses.
REQ-002 CLK  in  1  single clock; all state changes on rising edge.
REQ-003 RESET_N  in  1  reset, asynchronous, active-low.
REQ-004 REQ_VALID  in  1  pipeline MEM-stage access request.
REQ-005 REQ_READY  out  1  high only in IDLE; request accepted on an edge where REQ_VALID && REQ_READY.
REQ-006 REQ_WRITE  in  1  1 = store, 0 = load.
REQ-007 REQ_FUNCT3  in  3  loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores: 000 SB, 001 SH, 010 SW.
REQ-008 REQ_ADDR  in  ADDR_WIDTH  byte address.
REQ-009 REQ_WDATA  in  32  store data, right-aligned.
REQ-010 RESP_VALID  out  1  one-cycle completion pulse.
REQ-011 RESP_RDATA  out  32  extended load data; 0 for stores.
REQ-012 STALL  out  1  pipeline hold.
REQ-013 MEM_READ, MEM_WRITE  out  1 each  registered memory strobes, never both high.
REQ-014 MEM_ADDRESS  out  ADDR_WIDTH  word-aligned address, low two bits always 0.
REQ-015 MEM_WRITEDATA  out  32  word to memory; byte at lane k in bits [8k+7:8k] (little-endian).
REQ-016 MEM_READDATA  in  32  word from memory, same lane mapping.
REQ-017 MEM_BUSYWAIT  in  1  memory busy; request completes on first rising edge where a strobe is high and MEM_BUSYWAIT is 0.

Function
REQ-018 FSM states IDLE, RD, WR, RESP; on acceptance, latch REQ_WRITE, REQ_FUNCT3, REQ_ADDR, REQ_WDATA.
REQ-019 IDLE -> RD for loads, SB, SH; IDLE -> WR for SW.
REQ-020 RD: MEM_READ=1; on completion, loads capture extended data -> RESP; SB/SH merge the store bytes into the read word -> WR.
REQ-021 WR: MEM_WRITE=1; on completion -> RESP.
REQ-022 RESP: RESP_VALID=1 for exactly one cycle -> IDLE; a new request may be accepted in the cycle after RESP.
REQ-023 Byte lane = addr[1:0]; half lane = addr[1]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-024 MEM_ADDRESS and MEM_WRITEDATA are held stable while a strobe is high.
REQ-025 Zero-wait latency from acceptance edge to RESP_VALID high: load and SW 2 cycles, SB/SH 3 cycles; each MEM_BUSYWAIT-high edge adds one cycle.
REQ-026 STALL = (IDLE && REQ_VALID) || RD || WR; STALL is low in RESP.
REQ-027 Unlisted REQ_FUNCT3 codes (011, 110, 111) are treated as word access.
REQ-028 REQ inputs are ignored outside IDLE.

Reset
REQ-029 RESET_N low forces IDLE immediately, without waiting for a clock edge.
REQ-030 While in reset: MEM_READ, MEM_WRITE, RESP_VALID, STALL, RESP_RDATA, MEM_ADDRESS and MEM_WRITEDATA are 0; REQ_READY is 1.
REQ-031 An access in flight when reset asserts is abandoned with no RESP_VALID; a partial read-modify-write issues no write.

Configuration
REQ-032 Macro MISALIGN_TRAP_EN defined: adds output MISALIGN (1 bit); an LH/LHU/SH with addr[0]=1, or a word access with addr[1:0]!=0, goes IDLE -> RESP with no memory strobe, RESP_RDATA=0, MISALIGN=1 coincident with RESP_VALID.
REQ-033 Macro undefined: no MISALIGN port; misaligned offsets are truncated (half: addr[0] ignored; word: addr[1:0] ignored).

Structure
REQ-034 Package mem_access_pkg holds the funct3 constants, the FSM state typedef and the lane-width constants.
REQ-035 Sub-module mem_lane_align (combinational) performs load extract/extend and store merge; the FSM stays in mem_access_unit.

Verification
REQ-036 Zero-wait SW: addr 0x10, data 0xDEADBEEF -> one MEM_WRITE cycle, MEM_ADDRESS 0x10, MEM_WRITEDATA 0xDEADBEEF, RESP_VALID 2 cycles after acceptance.
REQ-037 Memory word 0x80FF7F01 at 0x20: LB 0x23 -> 0xFFFFFF80; LBU 0x23 -> 0x00000080; LH 0x22 -> 0xFFFF80FF; LHU 0x20 -> 0x00007F01.
REQ-038 SB 0xAB to 0x21 over 0x11223344 -> MEM_READ then MEM_WRITE of 0x1122AB44, RESP_VALID 3 cycles after acceptance.
REQ-039 LW with MEM_BUSYWAIT high for 3 edges -> MEM_READ high for 4 cycles, STALL high throughout, RESP_VALID on the 5th cycle after acceptance.
REQ-040 RESET_N low during the RD phase of an SH -> strobes drop without a clock edge, no MEM_WRITE, no RESP_VALID, REQ_READY=1.
REQ-041 LW at 0x22: with MISALIGN_TRAP_EN -> no strobe, MISALIGN=1, RESP_RDATA=0; without the macro -> MEM_ADDRESS 0x20.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit: funct3 codes, lane widths,
// FSM state encoding and access-size decoding.
package mem_access_pkg;

   localparam logic [2:0] F3_BYTE   = 3'b000;
   localparam logic [2:0] F3_HALF   = 3'b001;
   localparam logic [2:0] F3_WORD   = 3'b010;
   localparam logic [2:0] F3_BYTE_U = 3'b100;
   localparam logic [2:0] F3_HALF_U = 3'b101;

   localparam int BYTE_W = 8;
   localparam int HALF_W = 16;
   localparam int WORD_W = 32;

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

   // Codes outside the byte/half set (010, 011, 110, 111) all mean a word access.
   function automatic size_t access_size(input logic [2:0] funct3);
      case (funct3)
         F3_BYTE, F3_BYTE_U: access_size = SZ_BYTE;
         F3_HALF, F3_HALF_U: access_size = SZ_HALF;
         default:            access_size = SZ_WORD;
      endcase
   endfunction

   function automatic logic is_unsigned(input logic [2:0] funct3);
      is_unsigned = (funct3 == F3_BYTE_U) || (funct3 == F3_HALF_U);
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: extracts and extends load data from a memory
// word, and merges byte/half store data into a read word.
module mem_lane_align
   import mem_access_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   logic [4:0]  byte_shift;
   logic [4:0]  half_shift;
   logic [31:0] byte_word;
   logic [31:0] half_word;
   logic [BYTE_W-1:0] sel_byte;
   logic [HALF_W-1:0] sel_half;

   // Half accesses use only offset[1]; a set offset[0] is simply dropped.
   assign byte_shift = {offset, 3'b000};
   assign half_shift = {offset[1], 4'b0000};
   assign byte_word  = rdata >> byte_shift;
   assign half_word  = rdata >> half_shift;
   assign sel_byte   = byte_word[BYTE_W-1:0];
   assign sel_half   = half_word[HALF_W-1:0];

   // Select extension for loads and the replaced lane for partial stores.
   always_comb begin
      load_data  = rdata;
      merge_data = wdata;
      case (access_size(funct3))
         SZ_BYTE: begin
            load_data = is_unsigned(funct3) ? {{(WORD_W-BYTE_W){1'b0}}, sel_byte}
                                            : {{(WORD_W-BYTE_W){sel_byte[BYTE_W-1]}}, sel_byte};
            merge_data = (rdata & ~(32'h0000_00FF << byte_shift))
                       | ({{(WORD_W-BYTE_W){1'b0}}, wdata[BYTE_W-1:0]} << byte_shift);
         end
         SZ_HALF: begin
            load_data = is_unsigned(funct3) ? {{(WORD_W-HALF_W){1'b0}}, sel_half}
                                            : {{(WORD_W-HALF_W){sel_half[HALF_W-1]}}, sel_half};
            merge_data = (rdata & ~(32'h0000_FFFF << half_shift))
                       | ({{(WORD_W-HALF_W){1'b0}}, wdata[HALF_W-1:0]} << half_shift);
         end
         default: begin
            load_data  = rdata;
            merge_data = wdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: turns byte/half/word loads and stores into word
// memory transactions, doing read-modify-write for SB/SH.
// Optional build macro MISALIGN_TRAP_EN adds the misalign output and traps
// misaligned half/word accesses instead of truncating the offset.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  stall,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [31:0]           mem_writedata,
   input  logic [31:0]           mem_readdata,
   input  logic                  mem_busywait
`ifdef MISALIGN_TRAP_EN
   ,
   output logic                  misalign
`endif
);

   state_t state, next_state;

   logic                  write_q;
   logic [2:0]            funct3_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;
   logic [31:0]           rdata_q;
   logic [31:0]           load_data;
   logic [31:0]           merge_data;
   logic                  accept;
   logic                  trap_req;

   assign accept = req_valid && (state == S_IDLE);

`ifdef MISALIGN_TRAP_EN
   logic misalign_q;
   assign trap_req = ((access_size(req_funct3) == SZ_HALF) && req_addr[0])
                  || ((access_size(req_funct3) == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
   assign trap_req = 1'b0;
`endif

   mem_lane_align u_align (
      .funct3     (funct3_q),
      .offset     (addr_q[1:0]),
      .rdata      (mem_readdata),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   // State register; reset abandons any access in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= next_state;
   end

   // Next state: SW goes straight to write, everything else reads first.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               if (trap_req)
                  next_state = S_RESP;
               else if (req_write && (access_size(req_funct3) == SZ_WORD))
                  next_state = S_WR;
               else
                  next_state = S_RD;
            end
         end
         S_RD:    if (!mem_busywait) next_state = write_q ? S_WR : S_RESP;
         S_WR:    if (!mem_busywait) next_state = S_RESP;
         S_RESP:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Handshake and strobe outputs decoded from the registered state.
   always_comb begin
      req_ready  = (state == S_IDLE);
      mem_read   = (state == S_RD);
      mem_write  = (state == S_WR);
      resp_valid = (state == S_RESP);
      stall      = reset_n && (((state == S_IDLE) && req_valid) || (state == S_RD) || (state == S_WR));
`ifdef MISALIGN_TRAP_EN
      misalign   = (state == S_RESP) && misalign_q;
`endif
   end

   // Request latch plus read-completion capture of load data or merged store word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         write_q    <= 1'b0;
         funct3_q   <= 3'b000;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
`ifdef MISALIGN_TRAP_EN
         misalign_q <= 1'b0;
`endif
      end else if (accept) begin
         write_q    <= req_write;
         funct3_q   <= req_funct3;
         addr_q     <= req_addr;
         wdata_q    <= req_wdata;
         rdata_q    <= '0;
`ifdef MISALIGN_TRAP_EN
         misalign_q <= trap_req;
`endif
      end else if ((state == S_RD) && !mem_busywait) begin
         if (write_q) wdata_q <= merge_data;
         else         rdata_q <= load_data;
      end
   end

   assign mem_address   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign mem_writedata = wdata_q;
   assign resp_rdata    = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 16-word memory responder with programmable
// busy-wait, directed scenarios and a randomized run against a reference model.
module tb_mem_access_unit;

   localparam int ADDR_WIDTH = 32;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        mem_busywait = 1'b0;
   logic        req_ready, resp_valid, stall, mem_read, mem_write;
   logic [31:0] resp_rdata, mem_address, mem_writedata, mem_readdata;
`ifdef MISALIGN_TRAP_EN
   logic        misalign;
`endif

   logic [31:0] mem [16];
   int total = 0;
   int passed = 0;
   int busy_left = 0;

   assign mem_readdata = mem[mem_address[5:2]];

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .stall(stall),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
      .mem_busywait(mem_busywait)
`ifdef MISALIGN_TRAP_EN
      , .misalign(misalign)
`endif
   );

   // Reference: result of one access from byte counts and lane arithmetic.
   function automatic void ref_access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                      input logic [31:0] wd, input logic [31:0] old, input int busy,
                                      output logic [31:0] e_rdata, output logic [31:0] e_word,
                                      output int e_lat, output int e_rd, output int e_wr, output logic e_mis);
      int nbytes, off;
      longint mask, v, w;
      nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      off    = (int'(addr[1:0]) / nbytes) * nbytes;
      mask   = (longint'(1) << (8 * nbytes)) - 1;
      v      = (longint'(old) >> (8 * off)) & mask;
      if (!f3[2] && nbytes < 4 && v >= (mask + 1) / 2) v = v - (mask + 1);
      w      = (longint'(old) & ~(mask << (8 * off))) | ((longint'(wd) & mask) << (8 * off));
      e_mis  = 1'b0;
`ifdef MISALIGN_TRAP_EN
      e_mis  = (int'(addr[1:0]) % nbytes) != 0;
`endif
      if (e_mis) begin
         e_rdata = 0; e_word = old; e_lat = 1; e_rd = 0; e_wr = 0;
      end else if (!wr) begin
         e_rdata = 32'(v); e_word = old; e_lat = 2 + busy; e_rd = 1 + busy; e_wr = 0;
      end else if (nbytes == 4) begin
         e_rdata = 0; e_word = 32'(w); e_lat = 2 + busy; e_rd = 0; e_wr = 1 + busy;
      end else begin
         e_rdata = 0; e_word = 32'(w); e_lat = 3 + busy; e_rd = 1 + busy; e_wr = 1;
      end
   endfunction

   // Drives one request, plays the memory, and reports what the DUT did.
   task automatic run_access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input int nbusy, input logic scramble,
                             output int lat, output logic [31:0] rdata, output int rd_cyc,
                             output int wr_cyc, output logic [31:0] rd_addr, output logic [31:0] wr_addr,
                             output logic mis, output int proto);
      logic prev_rd, prev_wr;
      logic [31:0] prev_a, prev_d;
      lat = -1; rdata = 0; rd_cyc = 0; wr_cyc = 0; rd_addr = 0; wr_addr = 0; mis = 0; proto = 0;
      prev_rd = 0; prev_wr = 0; prev_a = 0; prev_d = 0;
      @(negedge clk);
      if (resp_valid) proto++;
      req_valid = 1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      busy_left = nbusy; mem_busywait = 0;
      #1;
      if (!req_ready || !stall) proto++;
      @(posedge clk);
      #1;
      req_valid = scramble;
      if (scramble) begin
         req_write = 1'($urandom); req_funct3 = 3'($urandom);
         req_addr = $urandom; req_wdata = $urandom;
      end
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if ((mem_read || mem_write) && busy_left > 0) begin
            mem_busywait = 1; busy_left--;
         end else mem_busywait = 0;
         if (mem_read && mem_write) proto++;
         if ((mem_read || mem_write) && mem_address[1:0] != 2'b00) proto++;
         if (stall !== (mem_read || mem_write)) proto++;
         if (req_ready) proto++;
         if (((prev_rd && mem_read) || (prev_wr && mem_write)) &&
             (mem_address !== prev_a || mem_writedata !== prev_d)) proto++;
         prev_rd = mem_read; prev_wr = mem_write; prev_a = mem_address; prev_d = mem_writedata;
         if (mem_read) begin rd_cyc++; rd_addr = mem_address; end
         if (mem_write) begin
            wr_cyc++; wr_addr = mem_address;
            if (!mem_busywait) mem[mem_address[5:2]] = mem_writedata;
         end
         if (resp_valid) begin
            lat = cyc; rdata = resp_rdata;
`ifdef MISALIGN_TRAP_EN
            mis = misalign;
`endif
            break;
         end
      end
      req_valid = 0; mem_busywait = 0;
   endtask

   task automatic test_reset();
      req_valid = 1;
      #3;
      total++;
      if ({req_ready, stall, mem_read, mem_write, resp_valid} !== 5'b10000)
         $display("FAIL reset_ctrl got %b want 10000", {req_ready, stall, mem_read, mem_write, resp_valid});
      else passed++;
      @(posedge clk); #1;
      total++;
      if ({resp_rdata, mem_address, mem_writedata} !== 96'd0)
         $display("FAIL reset_data got %h want 0", {resp_rdata, mem_address, mem_writedata});
      else passed++;
      req_valid = 0;
      @(negedge clk);
      reset_n = 1;
   endtask

   task automatic test_sw();
      int lat, rc, wc, pr; logic [31:0] rd, ra, wa; logic mi;
      for (int i = 0; i < 16; i++) mem[i] = 0;
      run_access(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, lat, rd, rc, wc, ra, wa, mi, pr);
      total++; if (lat !== 2) $display("FAIL sw_latency got %0d want 2", lat); else passed++;
      total++; if (rc !== 0 || wc !== 1) $display("FAIL sw_strobes got rd=%0d wr=%0d want rd=0 wr=1", rc, wc); else passed++;
      total++; if (wa !== 32'h10) $display("FAIL sw_addr got %h want 00000010", wa); else passed++;
      total++; if (mem[4] !== 32'hDEADBEEF) $display("FAIL sw_data got %h want deadbeef", mem[4]); else passed++;
      total++; if (pr !== 0) $display("FAIL sw_protocol got %0d errors want 0", pr); else passed++;
   endtask

   task automatic test_loads();
      logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
      logic [31:0] ads [4] = '{32'h23, 32'h23, 32'h22, 32'h20};
      logic [31:0] exs [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
      int lat, rc, wc, pr; logic [31:0] rd, ra, wa; logic mi;
      mem[8] = 32'h80FF7F01;
      for (int i = 0; i < 4; i++) begin
         run_access(0, f3s[i], ads[i], 32'h0, 0, 0, lat, rd, rc, wc, ra, wa, mi, pr);
         total++; if (rd !== exs[i]) $display("FAIL load%0d_data got %h want %h", i, rd, exs[i]); else passed++;
         total++; if (lat !== 2 || ra !== 32'h20) $display("FAIL load%0d_timing got lat=%0d addr=%h want lat=2 addr=00000020", i, lat, ra); else passed++;
      end
   endtask

   task automatic test_sb();
      int lat, rc, wc, pr; logic [31:0] rd, ra, wa; logic mi;
      mem[8] = 32'h11223344;
      run_access(1, 3'b000, 32'h21, 32'h000000AB, 0, 0, lat, rd, rc, wc, ra, wa, mi, pr);
      total++; if (lat !== 3) $display("FAIL sb_latency got %0d want 3", lat); else passed++;
      total++; if (rc !== 1 || wc !== 1) $display("FAIL sb_strobes got rd=%0d wr=%0d want rd=1 wr=1", rc, wc); else passed++;
      total++; if (mem[8] !== 32'h1122AB44) $display("FAIL sb_merge got %h want 1122ab44", mem[8]); else passed++;
      total++; if (wa !== 32'h20 || pr !== 0) $display("FAIL sb_proto got addr=%h err=%0d want addr=00000020 err=0", wa, pr); else passed++;
   endtask

   task automatic test_busywait();
      int lat, rc, wc, pr; logic [31:0] rd, ra, wa; logic mi;
      mem[3] = 32'h13579BDF;
      run_access(0, 3'b010, 32'h0C, 32'h0, 3, 0, lat, rd, rc, wc, ra, wa, mi, pr);
      total++; if (lat !== 5) $display("FAIL busy_latency got %0d want 5", lat); else passed++;
      total++; if (rc !== 4) $display("FAIL busy_read_cycles got %0d want 4", rc); else passed++;
      total++; if (rd !== 32'h13579BDF || pr !== 0) $display("FAIL busy_data got %h err=%0d want 13579bdf err=0", rd, pr); else passed++;
   endtask

   task automatic test_reset_midflight();
      int seen;
      mem[9] = 32'hCAFEF00D;
      @(negedge clk);
      req_valid = 1; req_write = 1; req_funct3 = 3'b001; req_addr = 32'h24; req_wdata = 32'h5555;
      @(posedge clk); #1;
      req_valid = 0;
      @(negedge clk); mem_busywait = 1;
      @(negedge clk);
      total++; if ({mem_read, mem_write} !== 2'b10) $display("FAIL rst_rd_phase got %b want 10", {mem_read, mem_write}); else passed++;
      #2 reset_n = 0;
      #1;
      total++;
      if ({req_ready, stall, mem_read, mem_write, resp_valid} !== 5'b10000)
         $display("FAIL rst_async_ctrl got %b want 10000", {req_ready, stall, mem_read, mem_write, resp_valid});
      else passed++;
      total++;
      if ({resp_rdata, mem_address, mem_writedata} !== 96'd0)
         $display("FAIL rst_async_data got %h want 0", {resp_rdata, mem_address, mem_writedata});
      else passed++;
      mem_busywait = 0; seen = 0;
      repeat (2) @(negedge clk);
      reset_n = 1;
      repeat (5) begin
         @(negedge clk);
         if (mem_write || resp_valid || mem_read) seen++;
      end
      total++; if (seen !== 0) $display("FAIL rst_abandon got %0d active cycles want 0", seen); else passed++;
   endtask

   task automatic test_misalign();
      int lat, rc, wc, pr; logic [31:0] rd, ra, wa; logic mi;
      mem[8] = 32'h80FF7F01;
      run_access(0, 3'b010, 32'h22, 32'h0, 0, 0, lat, rd, rc, wc, ra, wa, mi, pr);
`ifdef MISALIGN_TRAP_EN
      total++; if (lat !== 1 || rc !== 0 || wc !== 0) $display("FAIL trap_flow got lat=%0d rd=%0d wr=%0d want 1 0 0", lat, rc, wc); else passed++;
      total++; if (mi !== 1 || rd !== 0) $display("FAIL trap_flag got mis=%b data=%h want 1 0", mi, rd); else passed++;
`else
      total++; if (lat !== 2 || ra !== 32'h20) $display("FAIL trunc_addr got lat=%0d addr=%h want 2 00000020", lat, ra); else passed++;
      total++; if (rd !== 32'h80FF7F01) $display("FAIL trunc_data got %h want 80ff7f01", rd); else passed++;
`endif
   endtask

   task automatic test_back_to_back();
      int lat, rc, wc, pr; logic [31:0] rd, ra, wa; logic mi;
      run_access(1, 3'b010, 32'h30, 32'h0BADF00D, 0, 1, lat, rd, rc, wc, ra, wa, mi, pr);
      run_access(0, 3'b010, 32'h30, 32'h0, 0, 1, lat, rd, rc, wc, ra, wa, mi, pr);
      total++; if (rd !== 32'h0BADF00D || lat !== 2) $display("FAIL b2b_readback got %h lat=%0d want 0badf00d lat=2", rd, lat); else passed++;
      total++; if (pr !== 0) $display("FAIL b2b_protocol got %0d errors want 0", pr); else passed++;
   endtask

   task automatic test_random();
      logic [2:0]  ld_codes [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
      logic [2:0]  st_codes [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
      int lat, rc, wc, pr, busy, e_lat, e_rd, e_wr;
      logic [31:0] rd, ra, wa, addr, wd, old, e_rdata, e_word;
      logic mi, e_mis, wr;
      logic [2:0] f3;
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      for (int n = 0; n < 80; n++) begin
         wr   = 1'($urandom);
         f3   = wr ? st_codes[$urandom_range(0, 5)] : ld_codes[$urandom_range(0, 7)];
         addr = 32'($urandom_range(0, 63));
         wd   = $urandom;
         busy = $urandom_range(0, 2);
         old  = mem[addr[5:2]];
         ref_access(wr, f3, addr, wd, old, busy, e_rdata, e_word, e_lat, e_rd, e_wr, e_mis);
         run_access(wr, f3, addr, wd, busy, 1'($urandom), lat, rd, rc, wc, ra, wa, mi, pr);
         total++; if (lat !== e_lat) $display("FAIL rnd%0d_latency got %0d want %0d", n, lat, e_lat); else passed++;
         total++; if (rd !== e_rdata) $display("FAIL rnd%0d_rdata got %h want %h", n, rd, e_rdata); else passed++;
         total++; if (mem[addr[5:2]] !== e_word) $display("FAIL rnd%0d_memword got %h want %h", n, mem[addr[5:2]], e_word); else passed++;
         total++; if (rc !== e_rd || wc !== e_wr) $display("FAIL rnd%0d_strobes got rd=%0d wr=%0d want rd=%0d wr=%0d", n, rc, wc, e_rd, e_wr); else passed++;
         total++;
         if ((rc != 0 && ra !== {addr[31:2], 2'b00}) || (wc != 0 && wa !== {addr[31:2], 2'b00}))
            $display("FAIL rnd%0d_addr got rd=%h wr=%h want %h", n, ra, wa, {addr[31:2], 2'b00});
         else passed++;
         total++; if (mi !== e_mis || pr !== 0) $display("FAIL rnd%0d_misc got mis=%b err=%0d want mis=%b err=0", n, mi, pr, e_mis); else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_sw();
      test_loads();
      test_sb();
      test_busywait();
      test_reset_midflight();
      test_misalign();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
